// File: rtl/seq_rotate_right.sv
`default_nettype none
// ============================================================================
// Module   : seq_rotate_right
// Purpose  : Iterative 16-bit right rotator/shifter. An operand and a 4-bit
//            count are accepted through a start/ready handshake. The 1-, 2-,
//            4- and 8-position stages are applied on four successive cycles
//            through one mux stage per cycle. The registered result is then
//            presented under a valid/ready handshake.
//            Rotate-left is handled as a rotate-right by the negated count.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   start      in   1   request, accepted when start & in_ready at a clk edge
//   In         in  16   operand, sampled on accept
//   Cnt        in   4   shift/rotate amount 0..15, sampled on accept
//   Op         in   2   00 ROR, 01 SRL, 10 SRA, 11 ROL
//   in_ready   out  1   high only while idle
//   busy       out  1   high while shifting or holding a result
//   Out        out 16   result register
//   out_valid  out  1   result available
//   out_ready  in   1   consumer accepts the result
// ============================================================================
module seq_rotate_right (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] In,
  input  logic [3:0]  Cnt,
  input  logic [1:0]  Op,
  output logic        in_ready,
  output logic        busy,
  output logic [15:0] Out,
  output logic        out_valid,
  input  logic        out_ready
);

  // Operation encodings
  localparam logic [1:0] OP_ROR = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  localparam logic [1:0] LAST_STAGE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      state_q,  state_d;
  logic [15:0] work_q,   work_d;
  logic [3:0]  amt_q,    amt_d;
  logic [1:0]  op_q,     op_d;
  logic [1:0]  stage_q,  stage_d;
  logic [15:0] result_q, result_d;

  // --------------------------------------------------------------------------
  // Single-stage datapath: the shift distance is selected by stage_q, so each
  // cycle only ever needs one 4:1 mux level per bit plus the fill select.
  // --------------------------------------------------------------------------
  logic        sign_bit;
  logic [15:0] sh_rot;    // right rotate by 2^stage
  logic [15:0] sh_log;    // logical right shift by 2^stage
  logic [15:0] sh_ari;    // arithmetic right shift by 2^stage
  logic [15:0] sh_sel;    // candidate chosen by op
  logic        stage_en;  // this stage's bit of the amount
  logic [15:0] stage_out; // work value after this stage

  assign sign_bit = work_q[15];

  always_comb begin
    sh_rot = work_q;
    sh_log = work_q;
    sh_ari = work_q;
    case (stage_q)
      2'd0: begin
        sh_rot = {work_q[0],     work_q[15:1]};
        sh_log = {1'b0,          work_q[15:1]};
        sh_ari = {sign_bit,      work_q[15:1]};
      end
      2'd1: begin
        sh_rot = {work_q[1:0],   work_q[15:2]};
        sh_log = {2'b00,         work_q[15:2]};
        sh_ari = {{2{sign_bit}}, work_q[15:2]};
      end
      2'd2: begin
        sh_rot = {work_q[3:0],   work_q[15:4]};
        sh_log = {4'h0,          work_q[15:4]};
        sh_ari = {{4{sign_bit}}, work_q[15:4]};
      end
      default: begin
        sh_rot = {work_q[7:0],   work_q[15:8]};
        sh_log = {8'h00,         work_q[15:8]};
        sh_ari = {{8{sign_bit}}, work_q[15:8]};
      end
    endcase
  end

  always_comb begin
    sh_sel = sh_rot;
    case (op_q)
      OP_ROR:  sh_sel = sh_rot;
      OP_SRL:  sh_sel = sh_log;
      OP_SRA:  sh_sel = sh_ari;
      OP_ROL:  sh_sel = sh_rot;
      default: sh_sel = sh_rot;
    endcase
  end

  assign stage_en  = amt_q[stage_q];
  assign stage_out = stage_en ? sh_sel : work_q;

  // --------------------------------------------------------------------------
  // Next-state / datapath control
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    amt_d    = amt_q;
    op_d     = op_q;
    stage_d  = stage_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          work_d  = In;
          op_d    = Op;
          stage_d = 2'd0;
          // ROL by n is ROR by (16 - n) mod 16; n = 0 stays 0.
          amt_d   = (Op == OP_ROL) ? (4'd0 - Cnt) : Cnt;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        work_d  = stage_out;
        stage_d = stage_q + 2'd1;
        if (stage_q == LAST_STAGE) begin
          result_d = stage_out;
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      work_q   <= 16'h0000;
      amt_q    <= 4'h0;
      op_q     <= 2'b00;
      stage_q  <= 2'd0;
      result_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      amt_q    <= amt_d;
      op_q     <= op_d;
      stage_q  <= stage_d;
      result_q <= result_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: all decoded from registered state, none from out_ready.
  // --------------------------------------------------------------------------
  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_SHIFT) || (state_q == S_DONE);
  assign out_valid = (state_q == S_DONE);
  assign Out       = result_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_rotate_right.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_rotate_right
// Purpose  : Self-checking bench for seq_rotate_right. Expected results are
//            queued when an operation is accepted and compared when the
//            result retires.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_rotate_right;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] in_data;
  logic [3:0]  cnt;
  logic [1:0]  op;
  logic        in_ready;
  logic        busy;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int          n_checks;
  int          n_errors;
  int          cyc;
  logic [15:0] exp_q[$];

  seq_rotate_right dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .In        (in_data),
    .Cnt       (cnt),
    .Op        (op),
    .in_ready  (in_ready),
    .busy      (busy),
    .Out       (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] x, input logic [3:0] n,
                                        input logic [1:0] o);
    logic [31:0]        dd;
    logic [31:0]        t;
    logic signed [15:0] s;
    dd = {x, x};
    s  = x;
    case (o)
      2'b00:   begin t = dd >> n; model = t[15:0]; end
      2'b01:   model = x >> n;
      2'b10:   model = s >>> n;
      default: begin t = dd << n; model = t[31:16]; end
    endcase
  endfunction

  // Result monitor: sampled on the falling edge, before the retiring edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 32'd1, 32'd0);
      end else begin
        check("result", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  // Present one request and wait (bounded) until it is accepted.
  task automatic start_op(input logic [15:0] d, input logic [3:0] c, input logic [1:0] o,
                          input logic [15:0] exp, input bit push);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; in_data = d; cnt = c; op = o;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (ok) begin
      if (push) exp_q.push_back(exp);
      @(posedge clk); #1;
    end else begin
      check("accept_timeout", 32'd0, 32'd1);
    end
    start = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && in_ready) ok = 1'b1;
    end
    check("drain", {31'd0, ok}, 32'd1);
  endtask

  logic [15:0] t_in [6]  = '{16'h8000, 16'h8000, 16'h7FF0, 16'h1234, 16'h1234, 16'h8001};
  logic [3:0]  t_cnt[6]  = '{4'd15,    4'd15,    4'd4,     4'd4,     4'd0,     4'd1};
  logic [1:0]  t_op [6]  = '{2'b01,    2'b10,    2'b10,    2'b11,    2'b11,    2'b11};
  logic [15:0] t_exp[6]  = '{16'h0001, 16'hFFFF, 16'h07FF, 16'h2341, 16'h1234, 16'h0003};

  initial begin
    int accepted;
    int last;
    int guard;
    bit ok;

    n_checks  = 0;
    n_errors  = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    in_data   = 16'h0;
    cnt       = 4'h0;
    op        = 2'b00;
    out_ready = 1'b1;

    // Reset state
    #22;
    check("rst_out",      {16'h0, out_data}, 32'h0);
    check("rst_valid",    {31'd0, out_valid}, 32'd0);
    check("rst_busy",     {31'd0, busy},      32'd0);
    check("rst_in_ready", {31'd0, in_ready},  32'd1);
    rst_n = 1'b1;

    // ROR with latency check: valid exactly after the 4th edge past accept
    start_op(16'h1234, 4'd4, 2'b00, 16'h4123, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("lat_valid_low", {31'd0, out_valid}, 32'd0);
      check("lat_busy",      {31'd0, busy},      32'd1);
    end
    @(negedge clk);
    check("lat_valid_high", {31'd0, out_valid}, 32'd1);
    wait_drain();

    // Directed shift / rotate vectors
    for (int i = 0; i < 6; i++) begin
      start_op(t_in[i], t_cnt[i], t_op[i], t_exp[i], 1'b1);
      wait_drain();
    end

    // Backpressure with ignored start pulses
    @(posedge clk); #1;
    out_ready = 1'b0;
    start_op(16'h1234, 4'd4, 2'b11, 16'h2341, 1'b1);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (out_valid) ok = 1'b1;
    end
    check("bp_reach_done", {31'd0, ok}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      start = 1'b1; in_data = 16'hBEEF; cnt = 4'd1; op = 2'b00;
      @(negedge clk);
      check("bp_out",      {16'h0, out_data}, 32'h2341);
      check("bp_valid",    {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready},  32'd0);
    end
    @(posedge clk); #1;
    start     = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    start_op(16'h8001, 4'd1, 2'b00, 16'hC000, 1'b1);
    wait_drain();

    // Reset in the middle of SHIFT
    start_op(16'h5555, 4'd3, 2'b00, 16'h0000, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out",      {16'h0, out_data}, 32'h0);
    check("mid_rst_valid",    {31'd0, out_valid}, 32'd0);
    check("mid_rst_busy",     {31'd0, busy},      32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready},  32'd1);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_rst_valid", {31'd0, out_valid}, 32'd0);
    end
    start_op(16'h00F0, 4'd4, 2'b00, 16'h000F, 1'b1);
    wait_drain();

    // Back-to-back random traffic, start held high
    accepted = 0;
    last     = 0;
    guard    = 0;
    @(posedge clk); #1;
    start   = 1'b1;
    in_data = 16'($urandom);
    cnt     = 4'($urandom_range(15, 0));
    op      = 2'($urandom_range(3, 0));
    while (accepted < 1000 && guard < 20000) begin
      @(negedge clk);
      guard++;
      if (in_ready) begin
        exp_q.push_back(model(in_data, cnt, op));
        if (accepted > 0) check("b2b_period", 32'(cyc - last), 32'd6);
        last = cyc;
        accepted++;
        @(posedge clk); #1;
        in_data = 16'($urandom);
        cnt     = 4'($urandom_range(15, 0));
        op      = 2'($urandom_range(3, 0));
      end
    end
    start = 1'b0;
    check("b2b_count", 32'(accepted), 32'd1000);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
